multicycle_seq: RTL and testbench
=================================

Name: multicycle_seq

Overview:
Parametrised multicycle control sequencer for the MIPS-subset datapath. It generalises the fixed fetch/decode/execute flow in three ways: a configurable memory wait-state count, a start/done handshake with the long-latency mult/div unit (with timeout), and precise exceptions that write EPC. It drives datapath enables and mux selects only. ALU operation decode stays in the separate ALU control block.

Parameters:
MEM_LAT, 2, cycles from mem_rd/mem_w to data valid (legal range 1..15)
UNIT_TIMEOUT, 40, max UNIT_WAIT cycles before timeout exception (legal range 2..255)
CNT_W, 8, width of the internal wait/timeout counter

Ports:
clk  in  1  clock, rising edge
reset_in  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
ovf_in  in  1  ALU signed overflow, valid in EXEC
div_zero_in  in  1  divisor==0, valid in first UNIT_WAIT cycle
unit_done  in  1  mult/div result ready (single-cycle pulse)
reset_out  out  1  datapath reset
pc_w, ir_w, epc_w, mem_rd, mem_w, a_b_w, alu_out_w, rb_w, hi_lo_w  out  1 each  register/memory strobes
mux_pc  out  2  PC source: 00 ALU (PC+4), 01 jump target, 10 reg A, 11 exception vector
unit_start  out  1  one-cycle start pulse to mult/div
unit_sel  out  1  0 mult, 1 div
exc_cause  out  2  00 illegal, 01 overflow, 10 div-by-zero, 11 unit timeout
state_o  out  3  current state encoding, for debug/verification

Behaviour:
- Moore outputs: every strobe is decoded from the registered state (plus the counter). A strobe not listed for a state is 0.
- reset_in low: state goes to RESET asynchronously. All outputs are 0 except reset_out=1. exc_cause and the counter clear. This applies mid-operation, including during UNIT_WAIT.
- RESET: reset_out=1. The first rising edge with reset_in high moves to FETCH.
- FETCH (1 cycle): mem_rd=1, mux_pc=00. Counter loads MEM_LAT-1. Next state is IFWAIT.
- IFWAIT (MEM_LAT cycles): mem_rd=1.
  - Counter counts down.
  - When counter==0: ir_w=1, pc_w=1, mux_pc=00, then go to DECODE.
- DECODE (1 cycle): a_b_w=1. Next state by class:
  - ALU: R add/sub/and/slt/sll/srl/sra/sllv/srav/mfhi/mflo; I addi/addiu/slti/lui. Go to EXEC.
  - LOAD: lw/lh/lb. Go to EXEC.
  - STORE: sw/sh/sb. Go to EXEC.
  - JUMP: j, jal, R-jr. Go to EXEC.
  - UNIT: R-mult 0x18, R-div 0x1A. Go to UNIT_WAIT, with unit_sel latched (1 for div).
  - Anything else: go to EXC with cause 00.
- EXEC (1 cycle):
  - ALU/LOAD/STORE: alu_out_w=1.
  - ALU with ovf_in=1 and instruction add(0x20)/sub(0x22)/addi(0x08): go to EXC, cause 01. No rb_w is ever issued.
  - Other ALU: go to WB.
  - LOAD/STORE: go to MEMACC with counter=MEM_LAT-1.
  - j: pc_w=1, mux_pc=01, go to FETCH.
  - jal: pc_w=1, mux_pc=01, rb_w=1 (link), go to FETCH.
  - jr: pc_w=1, mux_pc=10, go to FETCH.
- MEMACC (MEM_LAT cycles): mem_rd=1 for loads, mem_w=1 for stores.
  - At counter==0, a load goes to WB and a store goes to FETCH.
- WB (1 cycle): rb_w=1. Go to FETCH.
- UNIT_WAIT:
  - First cycle: unit_start=1.
  - If unit_sel=1 and div_zero_in=1 in the first cycle: go to EXC, cause 10.
  - The counter increments each cycle.
  - On unit_done: hi_lo_w=1 in the following HILO cycle, then go to FETCH.
  - If counter reaches UNIT_TIMEOUT-1 without done: go to EXC, cause 11.
  - If unit_done and timeout coincide, done wins.
  - A unit_done outside UNIT_WAIT is ignored.
- HILO (1 cycle): hi_lo_w=1. Go to FETCH.
- EXC (1 cycle): epc_w=1, pc_w=1, mux_pc=11. exc_cause is registered on entry and held until the next exception or reset. Next state is FETCH.
- Latency with MEM_LAT=2:
  - ALU instruction: 6 cycles (FETCH, IFWAIT×2, DECODE, EXEC, WB).
  - lw: 8 cycles.
  - sw: 7 cycles.
  - j: 5 cycles.
- Counter arithmetic is unsigned CNT_W-bit. Parameters outside their legal ranges are unsupported.

Test Plan:
- Reset mid-UNIT_WAIT (reset_in low for 1 cycle) -> state_o=RESET immediately, reset_out=1, unit_start/hi_lo_w=0, exc_cause=00; after release, FETCH on the next edge.
- MEM_LAT=2, add (opcode 0x00, funct 0x20), ovf_in=0 -> ir_w at cycle 3, alu_out_w at cycle 5, single rb_w pulse at cycle 6, FETCH at cycle 7.
- add with ovf_in=1 in EXEC -> no rb_w; EXC with epc_w=pc_w=1, mux_pc=11, exc_cause=01.
- MEM_LAT=4, lw then sw -> mem_rd high 4 cycles in MEMACC followed by rb_w; store gives mem_w high 4 cycles with no rb_w.
- div with div_zero_in=1 -> unit_start pulse, then EXC with cause 10; mult with unit_done at wait cycle 10 -> hi_lo_w once, then FETCH.
- mult, unit_done never asserted, UNIT_TIMEOUT=40 -> EXC after 40 UNIT_WAIT cycles, cause 11; repeat with done on the timeout cycle -> HILO, no exception; opcode 0x3F -> EXC, cause 00.

Source files
------------

// File: rtl/multicycle_seq.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_seq
//  Description : Multicycle control sequencer for the MIPS-subset datapath.
//                It adds configurable memory wait states, a start/done
//                handshake with timeout for the mult/div unit, and precise
//                exceptions that write EPC.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_seq #(
    parameter int MEM_LAT      = 2,
    parameter int UNIT_TIMEOUT = 40,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset_in,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       ovf_in,
    input  logic       div_zero_in,
    input  logic       unit_done,
    output logic       reset_out,
    output logic       pc_w,
    output logic       ir_w,
    output logic       epc_w,
    output logic       mem_rd,
    output logic       mem_w,
    output logic       a_b_w,
    output logic       alu_out_w,
    output logic       rb_w,
    output logic       hi_lo_w,
    output logic [1:0] mux_pc,
    output logic       unit_start,
    output logic       unit_sel,
    output logic [1:0] exc_cause,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] LAT_M1     = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(UNIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [1:0] PC_ALU  = 2'b00;
    localparam logic [1:0] PC_JUMP = 2'b01;
    localparam logic [1:0] PC_REGA = 2'b10;
    localparam logic [1:0] PC_EXC  = 2'b11;

    localparam logic [1:0] CAUSE_ILL  = 2'b00;
    localparam logic [1:0] CAUSE_OVF  = 2'b01;
    localparam logic [1:0] CAUSE_DIVZ = 2'b10;
    localparam logic [1:0] CAUSE_TO   = 2'b11;

    // Low three bits double as the debug code. MEMACC shares the memory-wait
    // code with IFWAIT and HILO shares the register-write code with WB, so
    // RESET, FETCH and EXC stay uniquely visible on the 3-bit debug port.
    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_IFWAIT    = 4'd2,
        S_DECODE    = 4'd3,
        S_EXEC      = 4'd4,
        S_WB        = 4'd5,
        S_UNIT_WAIT = 4'd6,
        S_EXC       = 4'd7,
        S_MEMACC    = 4'd10,
        S_HILO      = 4'd13
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU   = 3'd0,
        CL_LOAD  = 3'd1,
        CL_STORE = 3'd2,
        CL_J     = 3'd3,
        CL_JAL   = 3'd4,
        CL_JR    = 3'd5,
        CL_UNIT  = 3'd6,
        CL_ILL   = 3'd7
    } cls_t;

    state_t           state;
    cls_t             cls;
    logic             ovf_chk;
    logic [CNT_W-1:0] cnt;

    cls_t             dec_cls;
    logic             dec_ovf;

    // Instruction class decode from the IR fields (consumed in DECODE)
    always_comb begin
        dec_cls = CL_ILL;
        dec_ovf = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h22: begin
                        dec_cls = CL_ALU;
                        dec_ovf = 1'b1;
                    end
                    6'h24, 6'h2A, 6'h00, 6'h02, 6'h03,
                    6'h04, 6'h07, 6'h10, 6'h12: dec_cls = CL_ALU;
                    6'h08:                      dec_cls = CL_JR;
                    6'h18, 6'h1A:               dec_cls = CL_UNIT;
                    default:                    dec_cls = CL_ILL;
                endcase
            end
            6'h08: begin
                dec_cls = CL_ALU;
                dec_ovf = 1'b1;
            end
            6'h09, 6'h0A, 6'h0F: dec_cls = CL_ALU;
            6'h23, 6'h21, 6'h20: dec_cls = CL_LOAD;
            6'h2B, 6'h29, 6'h28: dec_cls = CL_STORE;
            6'h02:               dec_cls = CL_J;
            6'h03:               dec_cls = CL_JAL;
            default:             dec_cls = CL_ILL;
        endcase
    end

    // Sequencer state, shared wait/timeout counter and latched instruction info
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state     <= S_RESET;
            cnt       <= '0;
            exc_cause <= CAUSE_ILL;
            cls       <= CL_ALU;
            ovf_chk   <= 1'b0;
            unit_sel  <= 1'b0;
        end else begin
            case (state)
                S_RESET: state <= S_FETCH;

                S_FETCH: begin
                    cnt   <= LAT_M1;
                    state <= S_IFWAIT;
                end

                S_IFWAIT: begin
                    if (cnt == '0) begin
                        state <= S_DECODE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                S_DECODE: begin
                    cls     <= dec_cls;
                    ovf_chk <= dec_ovf;
                    cnt     <= '0;
                    case (dec_cls)
                        CL_UNIT: begin
                            unit_sel <= (funct == 6'h1A);
                            state    <= S_UNIT_WAIT;
                        end
                        CL_ILL: begin
                            exc_cause <= CAUSE_ILL;
                            state     <= S_EXC;
                        end
                        default: state <= S_EXEC;
                    endcase
                end

                S_EXEC: begin
                    case (cls)
                        CL_ALU: begin
                            if (ovf_in && ovf_chk) begin
                                exc_cause <= CAUSE_OVF;
                                state     <= S_EXC;
                            end else begin
                                state <= S_WB;
                            end
                        end
                        CL_LOAD, CL_STORE: begin
                            cnt   <= LAT_M1;
                            state <= S_MEMACC;
                        end
                        default: state <= S_FETCH;
                    endcase
                end

                S_MEMACC: begin
                    if (cnt == '0) begin
                        state <= (cls == CL_LOAD) ? S_WB : S_FETCH;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                S_WB: state <= S_FETCH;

                S_UNIT_WAIT: begin
                    // Divide-by-zero is only sampled in the start cycle; a
                    // done pulse beats a timeout that lands in the same cycle.
                    if ((cnt == '0) && unit_sel && div_zero_in) begin
                        exc_cause <= CAUSE_DIVZ;
                        state     <= S_EXC;
                    end else if (unit_done) begin
                        state <= S_HILO;
                    end else if (cnt == TIMEOUT_M1) begin
                        exc_cause <= CAUSE_TO;
                        state     <= S_EXC;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                S_HILO: state <= S_FETCH;

                S_EXC: state <= S_FETCH;

                default: state <= S_RESET;
            endcase
        end
    end

    // Moore strobe decode from the registered state and counter
    always_comb begin
        reset_out  = 1'b0;
        pc_w       = 1'b0;
        ir_w       = 1'b0;
        epc_w      = 1'b0;
        mem_rd     = 1'b0;
        mem_w      = 1'b0;
        a_b_w      = 1'b0;
        alu_out_w  = 1'b0;
        rb_w       = 1'b0;
        hi_lo_w    = 1'b0;
        mux_pc     = PC_ALU;
        unit_start = 1'b0;
        state_o    = 3'd0;
        case (state)
            S_RESET: begin
                reset_out = 1'b1;
                state_o   = 3'd0;
            end
            S_FETCH: begin
                mem_rd  = 1'b1;
                state_o = 3'd1;
            end
            S_IFWAIT: begin
                mem_rd  = 1'b1;
                state_o = 3'd2;
                if (cnt == '0) begin
                    ir_w = 1'b1;
                    pc_w = 1'b1;
                end
            end
            S_DECODE: begin
                a_b_w   = 1'b1;
                state_o = 3'd3;
            end
            S_EXEC: begin
                state_o = 3'd4;
                case (cls)
                    CL_ALU, CL_LOAD, CL_STORE: alu_out_w = 1'b1;
                    CL_J: begin
                        pc_w   = 1'b1;
                        mux_pc = PC_JUMP;
                    end
                    CL_JAL: begin
                        pc_w   = 1'b1;
                        rb_w   = 1'b1;
                        mux_pc = PC_JUMP;
                    end
                    CL_JR: begin
                        pc_w   = 1'b1;
                        mux_pc = PC_REGA;
                    end
                    default: alu_out_w = 1'b0;
                endcase
            end
            S_MEMACC: begin
                state_o = 3'd2;
                mem_rd  = (cls == CL_LOAD);
                mem_w   = (cls == CL_STORE);
            end
            S_WB: begin
                rb_w    = 1'b1;
                state_o = 3'd5;
            end
            S_UNIT_WAIT: begin
                state_o    = 3'd6;
                unit_start = (cnt == '0);
            end
            S_HILO: begin
                hi_lo_w = 1'b1;
                state_o = 3'd5;
            end
            S_EXC: begin
                epc_w   = 1'b1;
                pc_w    = 1'b1;
                mux_pc  = PC_EXC;
                state_o = 3'd7;
            end
            default: reset_out = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_seq
//  Description : Self-checking bench for multicycle_seq. Two instances
//                (MEM_LAT=2 and MEM_LAT=4) share inputs; a per-instruction
//                cycle schedule built from the sequencing rules supplies the
//                expected outputs of the selected instance each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_seq;

    localparam int TO = 40;

    // strobe field: reset_out pc_w ir_w epc_w mem_rd mem_w a_b_w alu_out_w rb_w hi_lo_w
    localparam logic [9:0] RO  = 10'h200;
    localparam logic [9:0] PC  = 10'h100;
    localparam logic [9:0] IR  = 10'h080;
    localparam logic [9:0] EPC = 10'h040;
    localparam logic [9:0] RD  = 10'h020;
    localparam logic [9:0] WR  = 10'h010;
    localparam logic [9:0] AB  = 10'h008;
    localparam logic [9:0] AO  = 10'h004;
    localparam logic [9:0] RB  = 10'h002;
    localparam logic [9:0] HL  = 10'h001;
    localparam logic [9:0] NONE = 10'h000;

    // debug codes seen on state_o
    localparam logic [2:0] C_RST = 3'd0, C_F = 3'd1, C_MW = 3'd2, C_D = 3'd3;
    localparam logic [2:0] C_E = 3'd4, C_W = 3'd5, C_U = 3'd6, C_X = 3'd7;

    logic       clk = 1'b0;
    logic       reset_in = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic       ovf_in = 1'b0, div_zero_in = 1'b0, unit_done = 1'b0;

    always #5 clk = ~clk;

    logic        a_ro, a_pc, a_ir, a_epc, a_rd, a_wr, a_ab, a_ao, a_rb, a_hl, a_us, a_usel;
    logic [1:0]  a_mp, a_ec;
    logic [2:0]  a_st;
    logic        b_ro, b_pc, b_ir, b_epc, b_rd, b_wr, b_ab, b_ao, b_rb, b_hl, b_us, b_usel;
    logic [1:0]  b_mp, b_ec;
    logic [2:0]  b_st;

    multicycle_seq #(.MEM_LAT(2), .UNIT_TIMEOUT(TO), .CNT_W(8)) dut_a (
        .clk(clk), .reset_in(reset_in), .opcode(opcode), .funct(funct),
        .ovf_in(ovf_in), .div_zero_in(div_zero_in), .unit_done(unit_done),
        .reset_out(a_ro), .pc_w(a_pc), .ir_w(a_ir), .epc_w(a_epc), .mem_rd(a_rd),
        .mem_w(a_wr), .a_b_w(a_ab), .alu_out_w(a_ao), .rb_w(a_rb), .hi_lo_w(a_hl),
        .mux_pc(a_mp), .unit_start(a_us), .unit_sel(a_usel), .exc_cause(a_ec),
        .state_o(a_st)
    );

    multicycle_seq #(.MEM_LAT(4), .UNIT_TIMEOUT(TO), .CNT_W(8)) dut_b (
        .clk(clk), .reset_in(reset_in), .opcode(opcode), .funct(funct),
        .ovf_in(ovf_in), .div_zero_in(div_zero_in), .unit_done(unit_done),
        .reset_out(b_ro), .pc_w(b_pc), .ir_w(b_ir), .epc_w(b_epc), .mem_rd(b_rd),
        .mem_w(b_wr), .a_b_w(b_ab), .alu_out_w(b_ao), .rb_w(b_rb), .hi_lo_w(b_hl),
        .mux_pc(b_mp), .unit_start(b_us), .unit_sel(b_usel), .exc_cause(b_ec),
        .state_o(b_st)
    );

    int lat = 2;

    logic [18:0] obs_a, obs_b, obs;
    assign obs_a = {a_ro, a_pc, a_ir, a_epc, a_rd, a_wr, a_ab, a_ao, a_rb, a_hl,
                    a_mp, a_us, a_usel, a_ec, a_st};
    assign obs_b = {b_ro, b_pc, b_ir, b_epc, b_rd, b_wr, b_ab, b_ao, b_rb, b_hl,
                    b_mp, b_us, b_usel, b_ec, b_st};
    assign obs   = (lat == 2) ? obs_a : obs_b;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        ovf;
        logic        dz;
        logic        done;
        int          idx;
        int          cyc;
        logic [18:0] exp;
    } rec_t;

    rec_t q[$];

    int checks = 0;
    int errors = 0;

    // model state that persists across instructions
    logic       m_usel  = 1'b0;
    logic [1:0] m_cause = 2'b00;
    logic [5:0] cur_op, cur_fn;
    int         cur_idx = 0;
    int         cur_cyc = 0;

    localparam logic [11:0] POOL [0:23] = '{
        {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h2A},
        {6'h00, 6'h00}, {6'h00, 6'h03}, {6'h00, 6'h10}, {6'h00, 6'h12},
        {6'h08, 6'h15}, {6'h09, 6'h3F}, {6'h0F, 6'h01}, {6'h23, 6'h07},
        {6'h20, 6'h00}, {6'h2B, 6'h11}, {6'h28, 6'h22}, {6'h02, 6'h00},
        {6'h03, 6'h05}, {6'h00, 6'h08}, {6'h00, 6'h18}, {6'h00, 6'h1A},
        {6'h00, 6'h1A}, {6'h3F, 6'h00}, {6'h04, 6'h00}, {6'h00, 6'h01}
    };

    function automatic logic nz();
        return 1'($urandom & 1);
    endfunction

    // 0 ALU, 1 load, 2 store, 3 j, 4 jal, 5 jr, 6 mult/div, 7 illegal
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if (fn inside {6'h20, 6'h22, 6'h24, 6'h2A, 6'h00, 6'h02, 6'h03,
                           6'h04, 6'h07, 6'h10, 6'h12}) return 0;
            if (fn == 6'h08) return 5;
            if (fn inside {6'h18, 6'h1A}) return 6;
            return 7;
        end
        if (op inside {6'h08, 6'h09, 6'h0A, 6'h0F}) return 0;
        if (op inside {6'h23, 6'h21, 6'h20}) return 1;
        if (op inside {6'h2B, 6'h29, 6'h28}) return 2;
        if (op == 6'h02) return 3;
        if (op == 6'h03) return 4;
        return 7;
    endfunction

    function automatic logic [18:0] mk(input logic [2:0] st, input logic [9:0] sb,
                                       input logic [1:0] mp, input logic us);
        return {sb, mp, us, m_usel, m_cause, st};
    endfunction

    task automatic push(input logic [2:0] st, input logic [9:0] sb, input logic [1:0] mp,
                        input logic us, input logic ov, input logic dz, input logic dn);
        rec_t r;
        r.op = cur_op; r.fn = cur_fn; r.ovf = ov; r.dz = dz; r.done = dn;
        r.idx = cur_idx; r.cyc = cur_cyc; r.exp = mk(st, sb, mp, us);
        cur_cyc++;
        q.push_back(r);
    endtask

    // Expected cycle-by-cycle schedule of one instruction.
    // done_at: UNIT_WAIT cycle (1-based) carrying unit_done, 0 = never.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                         input logic dz, input int done_at);
        int  cls;
        bool_block: begin end
        cls = classify(op, fn);
        cur_op = op; cur_fn = fn; cur_idx++; cur_cyc = 1;
        push(C_F, RD, 2'b00, 1'b0, nz(), nz(), nz());
        for (int i = 0; i < lat; i++)
            push(C_MW, (i == lat - 1) ? (RD | IR | PC) : RD, 2'b00, 1'b0, nz(), nz(), nz());
        push(C_D, AB, 2'b00, 1'b0, nz(), nz(), nz());
        case (cls)
            0: begin
                if (ovf && ((op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) || op == 6'h08)) begin
                    push(C_E, AO, 2'b00, 1'b0, 1'b1, nz(), nz());
                    m_cause = 2'b01;
                    push(C_X, EPC | PC, 2'b11, 1'b0, nz(), nz(), nz());
                end else begin
                    push(C_E, AO, 2'b00, 1'b0, ovf, nz(), nz());
                    push(C_W, RB, 2'b00, 1'b0, nz(), nz(), nz());
                end
            end
            1, 2: begin
                push(C_E, AO, 2'b00, 1'b0, nz(), nz(), nz());
                for (int i = 0; i < lat; i++)
                    push(C_MW, (cls == 1) ? RD : WR, 2'b00, 1'b0, nz(), nz(), nz());
                if (cls == 1) push(C_W, RB, 2'b00, 1'b0, nz(), nz(), nz());
            end
            3: push(C_E, PC, 2'b01, 1'b0, nz(), nz(), nz());
            4: push(C_E, PC | RB, 2'b01, 1'b0, nz(), nz(), nz());
            5: push(C_E, PC, 2'b10, 1'b0, nz(), nz(), nz());
            6: begin
                m_usel = (fn == 6'h1A);
                for (int w = 1; w <= TO; w++) begin
                    if (w == 1 && m_usel && dz) begin
                        push(C_U, NONE, 2'b00, 1'b1, nz(), 1'b1, nz());
                        m_cause = 2'b10;
                        push(C_X, EPC | PC, 2'b11, 1'b0, nz(), nz(), nz());
                        break;
                    end else if (w == done_at) begin
                        push(C_U, NONE, 2'b00, w == 1, nz(), (w == 1) ? dz : nz(), 1'b1);
                        push(C_W, HL, 2'b00, 1'b0, nz(), nz(), nz());
                        break;
                    end else if (w == TO) begin
                        push(C_U, NONE, 2'b00, 1'b0, nz(), nz(), 1'b0);
                        m_cause = 2'b11;
                        push(C_X, EPC | PC, 2'b11, 1'b0, nz(), nz(), nz());
                    end else begin
                        push(C_U, NONE, 2'b00, w == 1, nz(), (w == 1) ? dz : nz(), 1'b0);
                    end
                end
            end
            default: begin
                m_cause = 2'b00;
                push(C_X, EPC | PC, 2'b11, 1'b0, nz(), nz(), nz());
            end
        endcase
    endtask

    task automatic chk(input logic [18:0] exp, input string tag, input int idx, input int cyc);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s instr%0d cyc%0d observed=%h expected=%h", tag, idx, cyc, obs, exp);
        end
    endtask

    // Replay up to n scheduled cycles: drive inputs and check at the falling edge.
    task automatic run_queue(input int n);
        rec_t r;
        for (int k = 0; k < n && q.size() > 0; k++) begin
            r = q.pop_front();
            @(negedge clk);
            opcode = r.op; funct = r.fn;
            ovf_in = r.ovf; div_zero_in = r.dz; unit_done = r.done;
            #1;
            chk(r.exp, "cycle", r.idx, r.cyc);
        end
    endtask

    // One-cycle low pulse on reset_in; the state must drop asynchronously.
    task automatic do_reset();
        @(negedge clk);
        unit_done = 1'b0; ovf_in = 1'b0; div_zero_in = 1'b0;
        reset_in = 1'b0;
        #1;
        m_cause = 2'b00;
        m_usel  = 1'b0;
        chk(mk(C_RST, RO, 2'b00, 1'b0), "reset_async", cur_idx, 0);
        @(negedge clk);
        chk(mk(C_RST, RO, 2'b00, 1'b0), "reset_hold", cur_idx, 0);
        reset_in = 1'b1;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                         input logic dz, input int done_at);
        build(op, fn, ovf, dz, done_at);
        run_queue(1000);
    endtask

    initial begin
        logic [11:0] e;
        // MEM_LAT=2 directed sequence
        lat = 2;
        do_reset();
        instr(6'h00, 6'h20, 1'b0, 1'b0, 0);   // add, no overflow
        instr(6'h00, 6'h20, 1'b1, 1'b0, 0);   // add, overflow -> EXC 01
        instr(6'h00, 6'h22, 1'b1, 1'b0, 0);   // sub, overflow
        instr(6'h08, 6'h00, 1'b1, 1'b0, 0);   // addi, overflow
        instr(6'h09, 6'h00, 1'b1, 1'b0, 0);   // addiu ignores overflow
        instr(6'h00, 6'h24, 1'b1, 1'b0, 0);   // and ignores overflow
        instr(6'h02, 6'h00, 1'b0, 1'b0, 0);   // j
        instr(6'h03, 6'h00, 1'b0, 1'b0, 0);   // jal
        instr(6'h00, 6'h08, 1'b0, 1'b0, 0);   // jr
        instr(6'h00, 6'h1A, 1'b0, 1'b1, 0);   // div by zero -> EXC 10
        instr(6'h00, 6'h18, 1'b0, 1'b0, 10);  // mult, done at wait cycle 10
        instr(6'h00, 6'h18, 1'b0, 1'b1, 10);  // mult ignores div_zero_in
        instr(6'h00, 6'h18, 1'b0, 1'b0, TO);  // done on the timeout cycle wins
        instr(6'h3F, 6'h00, 1'b0, 1'b0, 0);   // illegal -> EXC 00
        instr(6'h00, 6'h18, 1'b0, 1'b0, 0);   // mult timeout -> EXC 11
        instr(6'h00, 6'h1A, 1'b0, 1'b0, 1);   // div, done in first cycle
        instr(6'h23, 6'h00, 1'b0, 1'b0, 0);   // lw at MEM_LAT=2
        instr(6'h2B, 6'h00, 1'b0, 1'b0, 0);   // sw at MEM_LAT=2
        // reset in the middle of UNIT_WAIT
        instr(6'h00, 6'h18, 1'b0, 1'b0, 0);   // leaves exc_cause=11
        build(6'h00, 6'h1A, 1'b0, 1'b0, 0);
        run_queue(4 + 12);
        q.delete();
        do_reset();
        instr(6'h00, 6'h20, 1'b0, 1'b0, 0);

        // MEM_LAT=4 instance
        lat = 4;
        do_reset();
        instr(6'h23, 6'h00, 1'b0, 1'b0, 0);   // lw
        instr(6'h2B, 6'h00, 1'b0, 1'b0, 0);   // sw
        instr(6'h20, 6'h00, 1'b0, 1'b0, 0);   // lb
        instr(6'h29, 6'h00, 1'b0, 1'b0, 0);   // sh
        instr(6'h00, 6'h2A, 1'b0, 1'b0, 0);   // slt

        // randomized instruction streams on both instances
        for (int pass = 0; pass < 2; pass++) begin
            for (int n = 0; n < 40; n++) begin
                if ($urandom_range(0, 7) == 0) begin
                    e = 12'($urandom);
                end else begin
                    e = POOL[$urandom_range(0, 23)];
                end
                instr(e[11:6], e[5:0], nz(), nz(),
                      ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 45)));
            end
            lat = 2;
            do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
